// File: rtl/crypto_controller_if.sv
// Instruction/key bus between the crypto controller and its host/datapath.
// The controller drives everything except the instruction word.
interface crypto_controller_if #(
    parameter int KEY_WORDS = 6
);
    logic [31:0]          instruct;
    logic [31:0]          out;
    logic [4:0]           sliceSelector;
    logic [KEY_WORDS-1:0] writeEnableKey;

    modport master (
        output instruct,
        input  out,
        input  sliceSelector,
        input  writeEnableKey
    );

    modport slave (
        input  instruct,
        output out,
        output sliceSelector,
        output writeEnableKey
    );
endinterface

// File: rtl/crypto_controller.sv
// Crypto coprocessor instruction front-end: decodes one instruction word per
// clock, steers key words to one-hot key registers and holds the slice index.
module crypto_controller #(
    parameter int KEY_WORDS    = 6,
    parameter int DEFAULT_LOAD = 4
) (
    input  logic               clock,
    input  logic               reset,
    crypto_controller_if.slave bus
);

    localparam logic [2:0] MAXN = 3'(KEY_WORDS);
    localparam logic [2:0] DEFN = 3'(DEFAULT_LOAD);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_KEY  = 2'd1,
        SET_SLICE = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [2:0]           k, k_d;
    logic [2:0]           nload, nload_d;
    logic [2:0]           last, last_d;
    logic                 err, err_d;
    logic [31:0]          out_q, out_d;
    logic [4:0]           sel_q, sel_d;
    logic [KEY_WORDS-1:0] we_q, we_d;
    logic                 keydata;
    logic [2:0]           nfield;
    logic [2:0]           opcode;

    assign nfield = bus.instruct[6:4];
    assign opcode = bus.instruct[2:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            nload <= '0;
            last  <= '0;
            err   <= 1'b0;
            out_q <= '0;
            sel_q <= '0;
            we_q  <= '0;
        end else begin
            state <= state_d;
            k     <= k_d;
            nload <= nload_d;
            last  <= last_d;
            err   <= err_d;
            out_q <= out_d;
            sel_q <= sel_d;
            we_q  <= we_d;
        end
    end

    always_comb begin
        state_d = state;
        k_d     = k;
        nload_d = nload;
        last_d  = last;
        err_d   = err;
        sel_d   = sel_q;
        we_d    = '0;
        keydata = 1'b0;

        case (state)
            IDLE: begin
                if (bus.instruct[31]) begin
                    case (opcode)
                        3'b000: begin
                            state_d = LOAD_KEY;
                            k_d     = '0;
                            if (nfield == '0)
                                nload_d = DEFN;
                            else if (nfield > MAXN)
                                nload_d = MAXN;
                            else
                                nload_d = nfield;
                        end
                        3'b111:  state_d = SET_SLICE;
                        default: err_d   = 1'b1;
                    endcase
                end
            end
            LOAD_KEY: begin
                // bit31 is key data here, never a command
                keydata = 1'b1;
                we_d    = {{(KEY_WORDS-1){1'b0}}, 1'b1} << k;
                sel_d   = 5'(k);
                k_d     = k + 3'd1;
                if (k == nload - 3'd1) begin
                    state_d = IDLE;
                    last_d  = nload;
                    k_d     = '0;
                end
            end
            SET_SLICE: begin
                sel_d   = bus.instruct[4:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Status reports the state the word was sampled in, with the updated flags.
        out_d = keydata ? bus.instruct
                        : {23'b0, err_d, 1'b0, last_d, 2'b0, state};
    end

    assign bus.out            = out_q;
    assign bus.sliceSelector  = sel_q;
    assign bus.writeEnableKey = we_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert ($onehot0(we_q))
                else $error("writeEnableKey not one-hot");
        end
    end

endmodule

// File: tb/tb_crypto_controller.sv
// Self-checking bench for crypto_controller: directed vector table, hand-written
// load/reset sequences, then random stimulus against a behavioural model.
module tb_crypto_controller;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    always #5 clock = ~clock;

    crypto_controller_if #(.KEY_WORDS(6)) ifc ();

    crypto_controller #(.KEY_WORDS(6), .DEFAULT_LOAD(4)) dut (
        .clock (clock),
        .reset (rst),
        .bus   (ifc.slave)
    );

    int passed = 0;
    int total  = 0;

    // behavioural model: mode 0 idle, 1 loading key words, 2 awaiting slice
    int          m_mode = 0, m_idx = 0, m_n = 0, m_last = 0, m_err = 0;
    logic [31:0] m_out = '0;
    logic [4:0]  m_sel = '0;
    logic [5:0]  m_we  = '0;

    task automatic model(input logic r, input logic [31:0] w);
        int prev;
        int n;
        prev = m_mode;
        m_we = '0;
        if (r) begin
            m_mode = 0; m_idx = 0; m_n = 0; m_last = 0; m_err = 0;
            m_out = '0; m_sel = '0;
            return;
        end
        if (prev == 1) begin
            m_out = w;
            m_we  = 6'(1 << m_idx);
            m_sel = 5'(m_idx);
            m_idx++;
            if (m_idx == m_n) begin
                m_mode = 0;
                m_last = m_n;
            end
            return;
        end
        if (prev == 0 && w[31]) begin
            if (w[2:0] == 3'd0) begin
                n      = int'(w[6:4]);
                m_n    = (n == 0) ? 4 : ((n > 6) ? 6 : n);
                m_idx  = 0;
                m_mode = 1;
            end else if (w[2:0] == 3'd7) begin
                m_mode = 2;
            end else begin
                m_err = 1;
            end
        end else if (prev == 2) begin
            m_sel  = w[4:0];
            m_mode = 0;
        end
        m_out = 32'((m_err << 8) | (m_last << 4) | prev);
    endtask

    task automatic step(input logic r, input logic [31:0] w);
        @(negedge clock);
        rst          = r;
        ifc.instruct = w;
        @(posedge clock);
        #1;
        model(r, w);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic chk_all(input string name, input logic [31:0] eo,
                           input logic [4:0] es, input logic [5:0] ew);
        chk({name, " out"}, ifc.out, eo);
        chk({name, " sel"}, 32'(ifc.sliceSelector), 32'(es));
        chk({name, " we"},  32'(ifc.writeEnableKey), 32'(ew));
    endtask

    typedef struct {
        logic        r;
        logic [31:0] in;
        logic [31:0] eout;
        logic [4:0]  esel;
        logic [5:0]  ewe;
    } vec_t;

    vec_t vecs[21];

    initial begin
        logic [31:0] w;
        int unsigned sel;

        ifc.instruct = '0;

        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 5'd0, 6'h00};
        vecs[1]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 5'd0, 6'h00};
        vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0, 6'h00};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0, 6'h00};
        vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0, 6'h00};
        vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0000_0000, 5'd0, 6'h00};
        vecs[6]  = '{1'b0, 32'he031_8a99, 32'he031_8a99, 5'd0, 6'h01};
        vecs[7]  = '{1'b0, 32'h23f2_47b3, 32'h23f2_47b3, 5'd1, 6'h02};
        vecs[8]  = '{1'b0, 32'hed8f_f212, 32'hed8f_f212, 5'd2, 6'h04};
        vecs[9]  = '{1'b0, 32'hef0b_c156, 32'hef0b_c156, 5'd3, 6'h08};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0040, 5'd3, 6'h00};
        vecs[11] = '{1'b0, 32'h8000_0007, 32'h0000_0040, 5'd3, 6'h00};
        vecs[12] = '{1'b0, 32'h0000_0004, 32'h0000_0042, 5'd4, 6'h00};
        vecs[13] = '{1'b0, 32'h0000_0000, 32'h0000_0040, 5'd4, 6'h00};
        vecs[14] = '{1'b0, 32'h8000_0003, 32'h0000_0140, 5'd4, 6'h00};
        vecs[15] = '{1'b0, 32'h0000_0000, 32'h0000_0140, 5'd4, 6'h00};
        vecs[16] = '{1'b0, 32'h8000_0010, 32'h0000_0140, 5'd4, 6'h00};
        vecs[17] = '{1'b0, 32'h1234_5678, 32'h1234_5678, 5'd0, 6'h01};
        vecs[18] = '{1'b0, 32'h0000_0000, 32'h0000_0110, 5'd0, 6'h00};
        vecs[19] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 5'd0, 6'h00};
        vecs[20] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0, 6'h00};

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].in);
            chk_all($sformatf("vec%0d", i), vecs[i].eout, vecs[i].esel, vecs[i].ewe);
        end

        // six-word load with bit31 set in every data word
        step(1'b0, 32'h8000_0060);
        chk_all("six cmd", 32'h0000_0000, 5'd0, 6'h00);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h8000_0001 + 32'(i));
            chk_all($sformatf("six w%0d", i), 32'h8000_0001 + 32'(i), 5'(i), 6'(1 << i));
        end
        step(1'b0, 32'h0000_0000);
        chk_all("six status", 32'h0000_0060, 5'd5, 6'h00);

        // reset lands on the second key word
        step(1'b0, 32'h8000_0000);
        chk_all("rst cmd", 32'h0000_0060, 5'd5, 6'h00);
        step(1'b0, 32'haaaa_5555);
        chk_all("rst w0", 32'haaaa_5555, 5'd0, 6'h01);
        step(1'b1, 32'h5555_aaaa);
        chk_all("rst mid", 32'h0000_0000, 5'd0, 6'h00);
        step(1'b0, 32'h0000_0000);
        chk_all("rst nop1", 32'h0000_0000, 5'd0, 6'h00);
        step(1'b0, 32'h0000_0000);
        chk_all("rst nop2", 32'h0000_0000, 5'd0, 6'h00);

        // random phase against the model
        for (int i = 0; i < 1500; i++) begin
            w   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                w[31] = 1'b1;
                if (sel < 2)       w[2:0] = 3'd0;
                else if (sel == 2) w[2:0] = 3'd7;
            end
            step($urandom_range(0, 63) == 0, w);
            chk_all($sformatf("rnd%0d", i), m_out, m_sel, m_we);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
